// File: rtl/digit_disp_pkg.sv
// Shared digit-display definitions: code constants and active-low gfedcba segment patterns.
package digit_disp_pkg;

  localparam int unsigned CODE_W = 4;
  localparam int unsigned SEG_W  = 7;

  localparam logic [CODE_W-1:0] CODE_BLANK     = 4'd10;
  localparam logic [CODE_W-1:0] CODE_MAX_DIGIT = 4'd9;

  localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_DASH  = 7'b0111111;

endpackage

// File: rtl/hex7seg_decode.sv
// Combinational 4-bit code to 7-segment decoder; 10 is blank, 11-15 show a dash.
module hex7seg_decode
  import digit_disp_pkg::*;
(
  input  logic [CODE_W-1:0] code_i,
  output logic [SEG_W-1:0]  seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    case (code_i)
      4'd0:       seg_o = SEG_0;
      4'd1:       seg_o = SEG_1;
      4'd2:       seg_o = SEG_2;
      4'd3:       seg_o = SEG_3;
      4'd4:       seg_o = SEG_4;
      4'd5:       seg_o = SEG_5;
      4'd6:       seg_o = SEG_6;
      4'd7:       seg_o = SEG_7;
      4'd8:       seg_o = SEG_8;
      4'd9:       seg_o = SEG_9;
      CODE_BLANK: seg_o = SEG_BLANK;
      default:    seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/step_digit_history.sv
// Captures the sequencer digit on each step rising edge into an eight-deep history,
// drives the HEX displays (newest on HEX0) and a step counter on LEDR.
module step_digit_history
  import digit_disp_pkg::*;
#(
  parameter int unsigned DIGITS = 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              PIN_Y2,
  input  logic              KEY0,
  input  logic [CODE_W-1:0] code_in,
  input  logic              step_in,
  input  logic              hold_in,
  output logic [SEG_W-1:0]  HEX0,
  output logic [SEG_W-1:0]  HEX1,
  output logic [SEG_W-1:0]  HEX2,
  output logic [SEG_W-1:0]  HEX3,
  output logic [SEG_W-1:0]  HEX4,
  output logic [SEG_W-1:0]  HEX5,
  output logic [SEG_W-1:0]  HEX6,
  output logic [SEG_W-1:0]  HEX7,
  output logic [CNT_W-1:0]  LEDR,
  output logic              LEDG0
);

  logic              step_q;
  logic [CODE_W-1:0] hist_q [DIGITS];
  logic [CODE_W-1:0] hist_d [DIGITS];
  logic [SEG_W-1:0]  seg_q  [DIGITS];
  logic [SEG_W-1:0]  seg_d  [DIGITS];
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              flag_q, flag_d;
  logic              cap_c;

  for (genvar g = 0; g < DIGITS; g++) begin : g_dec
    hex7seg_decode u_dec (
      .code_i (hist_q[g]),
      .seg_o  (seg_d[g])
    );
  end

  // Rising-edge capture; hold drops the edge rather than deferring it.
  always_comb begin
    cap_c  = step_in & ~step_q & ~hold_in;
    hist_d = hist_q;
    cnt_d  = cnt_q;
    flag_d = cap_c;
    if (cap_c) begin
      hist_d[0] = code_in;
      for (int i = 1; i < int'(DIGITS); i++) begin
        hist_d[i] = hist_q[i-1];
      end
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge PIN_Y2) begin
    if (!KEY0) begin
      step_q <= 1'b0;
      cnt_q  <= '0;
      flag_q <= 1'b0;
      for (int i = 0; i < int'(DIGITS); i++) begin
        hist_q[i] <= CODE_BLANK;
        seg_q[i]  <= SEG_BLANK;
      end
    end else begin
      step_q <= step_in;
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
      for (int i = 0; i < int'(DIGITS); i++) begin
        hist_q[i] <= hist_d[i];
        seg_q[i]  <= seg_d[i];
      end
    end
  end

  assign HEX0  = seg_q[0];
  assign HEX1  = seg_q[1];
  assign HEX2  = seg_q[2];
  assign HEX3  = seg_q[3];
  assign HEX4  = seg_q[4];
  assign HEX5  = seg_q[5];
  assign HEX6  = seg_q[6];
  assign HEX7  = seg_q[7];
  assign LEDR  = cnt_q;
  assign LEDG0 = flag_q;

endmodule
